coin_accum: RTL

Parametrised coin accumulator for the ticket vending datapath. It takes raw per-denomination coin pulses from the acceptor, synchronises and edge-detects them, and keeps a per-channel coin count and a running balance. It also grants or refuses debit requests from the ticket dispatch controller and drives a retriggerable beep gate. It sits between the coin acceptor inputs and the ticket/change controller.

---
 rtl/coin_accum_if.sv | 35 +++
 rtl/coin_accum.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/coin_accum_if.sv
// coin_accum_if: groups the coin accumulator's data/handshake signals.
//   coin_in    raw coin pulses, one per channel (async to clk)
//   clr        clear counts/balance/ovf after a sale
//   spend_req  debit request, spend_amt sampled with it
//   spend_ack  one-cycle ack, spend_ok = debit granted
//   counts     per-channel coin counts, total = balance
//   reject     per-channel drop pulse, ovf = sticky saturation, beep gate
// master drives the inputs (dispatch controller / bench), slave is coin_accum.
interface coin_accum_if #(
  parameter int N_CH  = 5,
  parameter int CNT_W = 4,
  parameter int TOT_W = 10
);
  logic [N_CH-1:0]            coin_in;
  logic                       clr;
  logic                       spend_req;
  logic [TOT_W-1:0]           spend_amt;
  logic                       spend_ack;
  logic                       spend_ok;
  logic [N_CH-1:0][CNT_W-1:0] counts;
  logic [TOT_W-1:0]           total;
  logic [N_CH-1:0]            reject;
  logic                       ovf;
  logic                       beep;

  modport master (
    output coin_in, clr, spend_req, spend_amt,
    input  spend_ack, spend_ok, counts, total, reject, ovf, beep
  );

  modport slave (
    input  coin_in, clr, spend_req, spend_amt,
    output spend_ack, spend_ok, counts, total, reject, ovf, beep
  );
endinterface

// File: rtl/coin_accum.sv
// coin_accum: per-channel coin synchroniser/counter plus running balance
// with debit grant and retriggerable beep gate.
//   clk, rst  clock and synchronous active-high reset
//   bus       coin_accum_if.slave (see interface header for signals)

// One coin channel: 2-flop synchroniser, edge flop, saturating counter.
module coin_accum_lane #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin,
  input  logic             clr,
  output logic             acc,   // coin accepted this cycle
  output logic [CNT_W-1:0] cnt,
  output logic             rej
);
  logic s1, s2, s3;
  logic rise, sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // keeps running through clr so the edge state stays consistent
      s1 <= coin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign sat  = &cnt;
  assign acc  = rise & ~sat & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rej <= 1'b0;
    end else begin
      rej <= rise & sat & ~clr;
      if (clr)      cnt <= '0;
      else if (acc) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

module coin_accum #(
  parameter int                 N_CH        = 5,
  parameter int                 CNT_W       = 4,
  parameter int                 TOT_W       = 10,
  parameter logic [N_CH*8-1:0]  DENOMS      = {8'd100, 8'd50, 8'd10, 8'd5, 8'd1},
  parameter int                 BEEP_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  coin_accum_if.slave bus
);
  localparam int SUM_W = TOT_W + 3;
  localparam int BW    = $clog2(BEEP_CYCLES + 1);
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

  logic [N_CH-1:0]            acc;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q;
  logic [N_CH-1:0]            rej_q;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_lane
      coin_accum_lane #(.CNT_W(CNT_W)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .coin (bus.coin_in[g]),
        .clr  (bus.clr),
        .acc  (acc[g]),
        .cnt  (cnt_q[g]),
        .rej  (rej_q[g])
      );
    end
  endgenerate

  // sum of every denomination accepted this cycle
  logic [SUM_W-1:0] coin_sum;
  always_comb begin
    coin_sum = '0;
    for (int i = 0; i < N_CH; i++)
      if (acc[i]) coin_sum = coin_sum + SUM_W'(DENOMS[8*i +: 8]);
  end

  logic [TOT_W-1:0] total_q;
  logic             ovf_q;
  logic             ok_c, sat_c;
  logic [SUM_W-1:0] bal_nxt;

  // debit checked against the registered balance only; same-cycle coins
  // are added afterwards. ok implies amt <= total, so no underflow.
  assign ok_c    = bus.spend_req & ~bus.clr & (bus.spend_amt <= total_q);
  assign bal_nxt = SUM_W'(total_q) - (ok_c ? SUM_W'(bus.spend_amt) : '0) + coin_sum;
  assign sat_c   = |bal_nxt[SUM_W-1:TOT_W];

  logic [1:0] vld_pipe;   // spend request -> ack
  logic       ok_q;
  assign vld_pipe[0] = bus.spend_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q     <= '0;
      ovf_q       <= 1'b0;
      vld_pipe[1] <= 1'b0;
      ok_q        <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      ok_q        <= ok_c;
      if (bus.clr) begin
        total_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        total_q <= sat_c ? TOT_MAX : bal_nxt[TOT_W-1:0];
        if (sat_c) ovf_q <= 1'b1;
      end
    end
  end

  // retriggerable beep: reload on every accepted coin
  logic [BW-1:0] beep_cnt;
  always_ff @(posedge clk) begin
    if (rst)                 beep_cnt <= '0;
    else if (|acc)           beep_cnt <= BW'(BEEP_CYCLES);
    else if (beep_cnt != '0) beep_cnt <= beep_cnt - BW'(1);
  end

  assign bus.counts    = cnt_q;
  assign bus.reject    = rej_q;
  assign bus.total     = total_q;
  assign bus.ovf       = ovf_q;
  assign bus.spend_ack = vld_pipe[1];
  assign bus.spend_ok  = ok_q;
  assign bus.beep      = (beep_cnt != '0);
endmodule
